mw_queue: RTL and testbench
===========================

# mw_queue

Multi-way circular FIFO. It accepts up to PUSH_W entries and releases up to POP_W entries per cycle, and reports its occupancy every cycle. It sits between instruction fetch and decode/dispatch in the out-of-order core, replacing the single-entry-per-cycle instruction queue. A `flush` input on mispredict empties it.

## Interface
- WIDTH, default $bits(pc_instr_t): bits per entry.
- DEPTH, default 16: number of entries. Must be a power of two and ≥ max(PUSH_W, POP_W).
- PUSH_W, default INSTR_FETCH_NUM: maximum pushes per cycle.
- POP_W, default DECODE_WIDTH: maximum pops per cycle.
- Derived widths:
  - DB = $clog2(DEPTH)
  - CW = DB+1
  - PCW = $clog2(PUSH_W+1)
  - QCW = $clog2(POP_W+1)

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all contents (mispredict).
- push_cnt  in  PCW  number of lanes pushed this cycle. Lanes 0..push_cnt-1 are valid, in program order.
- push_data  in  PUSH_W×WIDTH  push lanes; lane 0 is the oldest.
- pop_cnt  in  QCW  number of entries consumed this cycle.
- pop_data  out  POP_W×WIDTH  read window; lane i holds the entry at head+i.
- pop_valid  out  POP_W  lane i is valid when i < count.
- count  out  CW  number of occupied entries.
- free  out  CW  DEPTH − count.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- Storage is a DEPTH-entry array with head and tail pointers, each CW bits wide.
  - The top bit of each pointer is the wrap bit.
  - The lower DB bits index the array.
  - count = tail − head, computed modulo 2^CW.
- Push is all-or-nothing.
  - It is accepted only when push_cnt ≤ free, using the registered free value.
  - If accepted, lanes 0..push_cnt-1 are written to (tail+i) mod DEPTH, and tail advances by push_cnt.
  - If push_cnt > free, the whole group is dropped and state is unchanged. Dropping a group is a protocol violation by the producer.
- Pop removes min(pop_cnt, count) entries: head advances by that amount. Requests beyond count are clamped, not errors.
- Space freed by a pop is not reusable for a push in the same cycle. `free` always reflects registered state.
- Simultaneous push and pop are both applied: the next count = count + pushed − popped.
- Wrap-around:
  - Writes and reads index modulo DEPTH.
  - The read window rotates across the array end, so lane i reads index (head+i) mod DEPTH.
- Flush has priority over push and pop.
  - Next cycle head = tail = 0.
  - All pushes in the flush cycle are discarded.
  - Array contents are not cleared.
- pop_data lanes with pop_valid = 0 are don't-care.

## Timing
- Reset, asynchronous on rst_n low:
  - head = tail = 0
  - count = 0, free = DEPTH
  - empty = 1, full = 0
  - pop_valid = 0
  - The array is not reset.
- All outputs are combinational from registered state only (bypass is the exception, see Configuration). There is no path from pop_cnt to any output.
- Push-to-visible latency is 1 cycle: an entry pushed in cycle N appears on pop_data in cycle N+1.
- Pop takes effect at the edge; the window shifts in the next cycle.
- Flush latency is 1 cycle: empty = 1 in the cycle after flush is asserted.
- Asserting rst_n low in the middle of a burst clears all state immediately. Pushes in that cycle are lost.

## Configuration
- Macro: MW_QUEUE_BYPASS_EN.
- Defined:
  - When count == 0 and flush = 0, pop_data lane i = push_data lane i and pop_valid[i] = (i < push_cnt).
  - Entries popped in the same cycle (p = min(pop_cnt, push_cnt)) are not written.
  - Only lanes p..push_cnt-1 are stored, and tail advances by push_cnt − p.
  - Zero-latency pass-through when empty.
- Undefined: no combinational push-to-pop path. Latency is always 1 cycle.

## Structure
- rv32i_types holds:
  - pc_instr_t
  - INSTR_FETCH_NUM and DECODE_WIDTH
  - a new parameter MWQ_DEPTH = 16, used at the instantiation site
- Sub-module mw_queue_window:
  - Purely combinational.
  - Rotates the array into the POP_W-lane read window from head.
  - Generates pop_valid from count.
- Pointer, count and write-enable logic stay in mw_queue.

## Test plan
All scenarios use DEPTH=8, PUSH_W=2, POP_W=2, WIDTH=32.
- Reset → count=0, free=8, empty=1, full=0, pop_valid=2'b00. Push A,B (push_cnt=2) → next cycle pop_data={B,A}, pop_valid=2'b11, count=2.
- Fill: four 2-wide pushes, no pops → full=1, free=0. A fifth push of 1 is dropped: count stays 8 and the window is unchanged.
- Wrap: push 6 entries, pop 6, push 4 (values 0x10..0x13) → entries written at indices 6,7,0,1. Window shows 0x10,0x11, then 0x12,0x13 after pop_cnt=2.
- Simultaneous: count=3, push_cnt=2, pop_cnt=2 → next count=3 and the window advances by 2. Same state with pop_cnt=2 but count=1 → pop clamps to 1.
- Flush while count=5 together with a push of 2 → next cycle count=0, empty=1, and the pushed entries are absent.
- With MW_QUEUE_BYPASS_EN defined: empty, push X,Y, pop_cnt=1 → pop_data[0]=X with pop_valid=2'b11 in the same cycle. Next cycle count=1 and pop_data[0]=Y.

Source files
------------

// File: rtl/mw_queue_pkg.sv
// Shared front-end types: fetched instruction record and fetch/decode widths
// used to size the instruction queue between fetch and decode.
package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pc_instr_t;

  localparam int INSTR_FETCH_NUM = 2;
  localparam int DECODE_WIDTH    = 2;
  localparam int MWQ_DEPTH       = 16;

endpackage

// File: rtl/mw_queue_window.sv
// Read window of the multi-way queue: rotates the storage array from head into
// POP_W lanes and marks lanes valid below the current occupancy.
module mw_queue_window
  import rv32i_types::*;
#(
  parameter int WIDTH = $bits(pc_instr_t),
  parameter int DEPTH = 16,
  parameter int POP_W = DECODE_WIDTH,
  localparam int DB = $clog2(DEPTH),
  localparam int CW = DB + 1
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] mem_i,
  input  logic [DB-1:0]               head_i,
  input  logic [CW-1:0]               count_i,
  output logic [POP_W-1:0][WIDTH-1:0] data_o,
  output logic [POP_W-1:0]            valid_o
);

  for (genvar i = 0; i < POP_W; i++) begin : g_lane
    logic [DB-1:0] idx;
    // DB-bit add wraps naturally across the array end
    assign idx        = head_i + DB'(i);
    assign data_o[i]  = mem_i[idx];
    assign valid_o[i] = CW'(i) < count_i;
  end

endmodule

// File: rtl/mw_queue.sv
// Multi-way circular instruction queue: up to PUSH_W in, POP_W out per cycle.
// Define MW_QUEUE_BYPASS_EN for zero-latency pass-through while empty.
module mw_queue
  import rv32i_types::*;
#(
  parameter int WIDTH  = $bits(pc_instr_t),
  parameter int DEPTH  = 16,
  parameter int PUSH_W = INSTR_FETCH_NUM,
  parameter int POP_W  = DECODE_WIDTH,
  localparam int DB  = $clog2(DEPTH),
  localparam int CW  = DB + 1,
  localparam int PCW = $clog2(PUSH_W + 1),
  localparam int QCW = $clog2(POP_W + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [PCW-1:0]              push_cnt,
  input  logic [PUSH_W-1:0][WIDTH-1:0] push_data,
  input  logic [QCW-1:0]              pop_cnt,
  output logic [POP_W-1:0][WIDTH-1:0] pop_data,
  output logic [POP_W-1:0]            pop_valid,
  output logic [CW-1:0]               count,
  output logic [CW-1:0]               free,
  output logic                        full,
  output logic                        empty
);

  logic [CW-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;

  logic [CW-1:0] push_ext, pop_ext, pop_n, byp_n;
  logic          push_ok;
  logic [PUSH_W-1:0]         wr_en;
  logic [PUSH_W-1:0][DB-1:0] wr_idx;

  assign count = tail_q - head_q;
  assign free  = CW'(DEPTH) - count;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;

  always_comb begin
    push_ext = CW'(push_cnt);
    pop_ext  = CW'(pop_cnt);
    // acceptance uses registered free: space popped this cycle is not reusable yet
    push_ok  = push_ext <= free;
    pop_n    = (pop_ext < count) ? pop_ext : count;
    byp_n    = '0;
`ifdef MW_QUEUE_BYPASS_EN
    if (empty && !flush) byp_n = (pop_ext < push_ext) ? pop_ext : push_ext;
`endif
    head_d = head_q + pop_n;
    tail_d = push_ok ? tail_q + push_ext - byp_n : tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end
    for (int j = 0; j < PUSH_W; j++) begin
      wr_en[j]  = push_ok && !flush && (CW'(j) < push_ext) && (CW'(j) >= byp_n);
      wr_idx[j] = DB'(tail_q + CW'(j) - byp_n);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // storage is intentionally not reset
  always_ff @(posedge clk) begin
    for (int j = 0; j < PUSH_W; j++)
      if (wr_en[j]) mem_q[wr_idx[j]] <= push_data[j];
  end

  logic [POP_W-1:0][WIDTH-1:0] win_data;
  logic [POP_W-1:0]            win_valid;

  mw_queue_window #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .POP_W(POP_W)
  ) u_window (
    .mem_i  (mem_q),
    .head_i (head_q[DB-1:0]),
    .count_i(count),
    .data_o (win_data),
    .valid_o(win_valid)
  );

`ifdef MW_QUEUE_BYPASS_EN
  logic byp_act;
  assign byp_act = empty && !flush;
  for (genvar i = 0; i < POP_W; i++) begin : g_byp
    if (i < PUSH_W) begin : g_in
      assign pop_data[i]  = byp_act ? push_data[i] : win_data[i];
      assign pop_valid[i] = byp_act ? (CW'(i) < push_ext) : win_valid[i];
    end else begin : g_out
      assign pop_data[i]  = win_data[i];
      assign pop_valid[i] = byp_act ? 1'b0 : win_valid[i];
    end
  end
`else
  assign pop_data  = win_data;
  assign pop_valid = win_valid;
`endif

endmodule

// File: tb/tb_mw_queue.sv
// Randomized scoreboard bench for mw_queue (DEPTH=8, PUSH_W=2, POP_W=2, WIDTH=32)
// checked against a queue-based reference model.
module tb_mw_queue;

  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       push_cnt = '0;
  logic [1:0][31:0] push_data = '0;
  logic [1:0]       pop_cnt = '0;
  logic [1:0][31:0] pop_data;
  logic [1:0]       pop_valid;
  logic [3:0]       count, free;
  logic             full, empty;

  mw_queue #(.WIDTH(32), .DEPTH(DEPTH), .PUSH_W(2), .POP_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_cnt (push_cnt),
    .push_data(push_data),
    .pop_cnt  (pop_cnt),
    .pop_data (pop_data),
    .pop_valid(pop_valid),
    .count    (count),
    .free     (free),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    logic [1:0]  vld;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // monitor: compares the window/occupancy the DUT presents against the next expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count", longint'(count), longint'(e.cnt));
      chk("free", longint'(free), longint'(DEPTH - e.cnt));
      chk("full", longint'(full), longint'(e.cnt == DEPTH));
      chk("empty", longint'(empty), longint'(e.cnt == 0));
      chk("pop_valid", longint'(pop_valid), longint'(e.vld));
      if (e.vld[0]) chk("pop_data0", longint'(pop_data[0]), longint'(e.d0));
      if (e.vld[1]) chk("pop_data1", longint'(pop_data[1]), longint'(e.d1));
    end
  end

  // drive one cycle; expectation for this cycle goes to the scoreboard, then the model advances
  task automatic step(input bit rst, input bit fl, input int pc, input int qc,
                      input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] lane[2];
    logic [31:0] d[2];
    int          p, popn, sz;
    bit          ok;
    @(posedge clk); #1;
    rst_n = !rst;
    flush = fl;
    push_cnt = 2'(pc);
    pop_cnt  = 2'(qc);
    push_data[0] = a;
    push_data[1] = b;
    lane[0] = a;
    lane[1] = b;
    if (rst) model.delete();
    sz = model.size();
    e.cnt = sz;
    e.vld = 2'b00;
    d[0] = '0;
    d[1] = '0;
    for (int i = 0; i < 2; i++)
      if (i < sz) begin e.vld[i] = 1'b1; d[i] = model[i]; end
`ifdef MW_QUEUE_BYPASS_EN
    if (!rst && !fl && sz == 0)
      for (int i = 0; i < 2; i++) begin e.vld[i] = (i < pc); d[i] = lane[i]; end
`endif
    e.d0 = d[0];
    e.d1 = d[1];
    exp_q.push_back(e);
    if (rst) return;
    if (fl) begin
      model.delete();
      return;
    end
    ok   = pc <= DEPTH - sz;
    p    = 0;
`ifdef MW_QUEUE_BYPASS_EN
    if (sz == 0) p = (qc < pc) ? qc : pc;
`endif
    popn = (qc < sz) ? qc : sz;
    repeat (popn) void'(model.pop_front());
    if (ok) for (int i = p; i < pc; i++) model.push_back(lane[i]);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    // reset state
    step(1, 0, 0, 0, '0, '0);
    step(1, 0, 0, 0, '0, '0);
    // basic push A,B
    step(0, 0, 2, 0, 32'hA, 32'hB);
    idle();
    step(0, 0, 0, 2, '0, '0);
    // fill, then an over-capacity push that must be dropped
    step(0, 0, 2, 0, 32'h100, 32'h101);
    step(0, 0, 2, 0, 32'h102, 32'h103);
    step(0, 0, 2, 0, 32'h104, 32'h105);
    step(0, 0, 2, 0, 32'h106, 32'h107);
    step(0, 0, 1, 0, 32'hDEAD, 32'h0);
    idle();
    repeat (4) step(0, 0, 0, 2, '0, '0);
    // wrap: push 6, pop 6, push 0x10..0x13
    step(0, 0, 2, 0, 32'h1, 32'h2);
    step(0, 0, 2, 0, 32'h3, 32'h4);
    step(0, 0, 2, 0, 32'h5, 32'h6);
    repeat (3) step(0, 0, 0, 2, '0, '0);
    step(0, 0, 2, 0, 32'h10, 32'h11);
    step(0, 0, 2, 0, 32'h12, 32'h13);
    idle();
    step(0, 0, 0, 2, '0, '0);
    step(0, 0, 0, 2, '0, '0);
    // simultaneous push/pop, then clamped pop
    step(0, 0, 2, 0, 32'h20, 32'h21);
    step(0, 0, 1, 0, 32'h22, 32'h0);
    step(0, 0, 2, 2, 32'h23, 32'h24);
    idle();
    step(0, 0, 0, 3, '0, '0);
    step(0, 0, 1, 0, 32'h30, 32'h0);
    step(0, 0, 2, 2, 32'h31, 32'h32);
    idle();
    // flush at count=5 together with a push
    step(0, 0, 2, 2, 32'h40, 32'h41);
    step(0, 0, 2, 0, 32'h42, 32'h43);
    step(0, 0, 1, 0, 32'h44, 32'h0);
    step(0, 1, 2, 0, 32'h50, 32'h51);
    idle();
    step(0, 0, 1, 0, 32'h60, 32'h0);
    idle();
    // randomized traffic, first phase biased toward filling
    for (int k = 0; k < 600; k++) begin
      bit rst, fl;
      int pc, qc;
      rst = ($urandom_range(0, 199) == 0);
      fl  = ($urandom_range(0, 29) == 0);
      pc  = $urandom_range(0, 2);
      qc  = (k < 300) ? $urandom_range(0, 1) : $urandom_range(0, 3);
      step(rst, fl, pc, qc, $urandom, $urandom);
    end
    // reset in the middle of a burst
    step(0, 0, 2, 0, 32'h70, 32'h71);
    step(1, 0, 2, 1, 32'h72, 32'h73);
    step(0, 0, 2, 0, 32'h74, 32'h75);
    idle();
    @(posedge clk); #1;
    push_cnt = '0;
    pop_cnt  = '0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
